// File: rtl/usr_pkg.sv
// Shared types for the universal shift register: operation encoding and helpers.
`timescale 1ns/1ps
package usr_pkg;

    localparam int MODE_W = 3;

    typedef enum logic [MODE_W-1:0] {
        HOLD = 3'b000,
        LOAD = 3'b001,
        SHL  = 3'b010,
        SHR  = 3'b011,
        ROTL = 3'b100,
        ROTR = 3'b101,
        ASR  = 3'b110,
        CLR  = 3'b111
    } mode_e;

    // Modes that move bits and therefore advance the word counter.
    function automatic logic is_shift(input mode_e m);
        return (m == SHL) || (m == SHR) || (m == ROTL) || (m == ROTR) || (m == ASR);
    endfunction

endpackage

// File: rtl/usr_shift_cnt.sv
// Wrap counter of shifts since the last load; pulses done for one cycle when WIDTH is reached.
`timescale 1ns/1ps
module usr_shift_cnt
    import usr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic Clk,
    input  logic reset,
    input  logic en,
    input  logic inc,
    input  logic clr,
    output logic done
);

    localparam int               CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_done;

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else if (en) begin
            if (clr) begin
                r_cnt  <= '0;
                r_done <= 1'b0;
            end else if (inc && (r_cnt == LAST)) begin
                r_cnt  <= '0;
                r_done <= 1'b1;
            end else if (inc) begin
                r_cnt  <= r_cnt + CNT_W'(1);
                r_done <= 1'b0;
            end else begin
                r_done <= 1'b0;
            end
        end
    end

    assign done = r_done;

endmodule

// File: rtl/univ_shift_reg.sv
// Universal WIDTH-bit register: hold/load/shift/rotate/clear with word-complete pulse.
// Optional even-parity output enabled by defining USR_PARITY_EN.
`timescale 1ns/1ps
module univ_shift_reg
    import usr_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic              Clk,
    input  logic              reset,
    input  logic              en,
    input  logic [MODE_W-1:0] mode,
    input  logic [WIDTH-1:0]  D,
    input  logic              sin,
    output logic [WIDTH-1:0]  Q,
    output logic [WIDTH-1:0]  Qb,
    output logic              sout,
    output logic              word_done
`ifdef USR_PARITY_EN
    ,
    output logic              parity
`endif
);

    mode_e            w_mode;
    logic [WIDTH-1:0] w_q_next;
    logic [WIDTH-1:0] r_q;
    logic             w_inc;
    logic             w_clr;
    logic             w_done;

    assign w_mode = mode_e'(mode);

    always_comb begin
        w_q_next = r_q;
        case (w_mode)
            HOLD:    w_q_next = r_q;
            LOAD:    w_q_next = D;
            SHL:     w_q_next = {r_q[WIDTH-2:0], sin};
            SHR:     w_q_next = {sin, r_q[WIDTH-1:1]};
            ROTL:    w_q_next = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
            ROTR:    w_q_next = {r_q[0], r_q[WIDTH-1:1]};
            ASR:     w_q_next = {r_q[WIDTH-1], r_q[WIDTH-1:1]};
            CLR:     w_q_next = '0;
            default: w_q_next = r_q;
        endcase
    end

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            r_q <= RESET_VAL;
        end else if (en) begin
            r_q <= w_q_next;
        end
    end

    assign w_inc = is_shift(w_mode);
    assign w_clr = (w_mode == LOAD) || (w_mode == CLR);

    usr_shift_cnt #(
        .WIDTH (WIDTH)
    ) u_shift_cnt (
        .Clk   (Clk),
        .reset (reset),
        .en    (en),
        .inc   (w_inc),
        .clr   (w_clr),
        .done  (w_done)
    );

    assign Q         = r_q;
    assign Qb        = ~r_q;
    // Left-moving modes expose the MSB; everything else exposes the LSB.
    assign sout      = ((w_mode == SHL) || (w_mode == ROTL)) ? r_q[WIDTH-1] : r_q[0];
    assign word_done = w_done;

`ifdef USR_PARITY_EN
    assign parity = ^r_q;
`endif

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg (WIDTH=8) with a reference model feeding a scoreboard.
`timescale 1ns/1ps
module tb_univ_shift_reg;
    import usr_pkg::*;

    logic       Clk;
    logic       reset;
    logic       en;
    logic [2:0] mode;
    logic [7:0] D;
    logic       sin;
    logic [7:0] Q;
    logic [7:0] Qb;
    logic       sout;
    logic       word_done;
`ifdef USR_PARITY_EN
    logic       parity;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [7:0] q;
        logic       so;
        logic       wd;
    } exp_t;

    exp_t sb[$];

    logic [7:0] m_q;
    int         m_cnt;
    logic       m_wd;

    univ_shift_reg #(
        .WIDTH     (8),
        .RESET_VAL (8'h00)
    ) dut (
        .Clk       (Clk),
        .reset     (reset),
        .en        (en),
        .mode      (mode),
        .D         (D),
        .sin       (sin),
        .Q         (Q),
        .Qb        (Qb),
        .sout      (sout),
        .word_done (word_done)
`ifdef USR_PARITY_EN
        ,
        .parity    (parity)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(negedge Clk) begin
        checks++;
        if (Qb !== ~Q) begin
            errors++;
            $display("FAIL qb_complement t=%0t: Qb=%h, expected %h", $time, Qb, ~Q);
        end
    end

    // Drive one operation, predict its result into the scoreboard, then step one clock.
    task automatic drive(input logic [2:0] m, input logic [7:0] d, input logic s, input logic e);
        logic [7:0] nq;
        logic       shift;
        exp_t       x;
        mode = m;
        D    = d;
        sin  = s;
        en   = e;
        if (e) begin
            nq    = m_q;
            shift = 1'b1;
            case (m)
                HOLD: shift = 1'b0;
                LOAD: begin nq = d; shift = 1'b0; end
                SHL:  nq = {m_q[6:0], s};
                SHR:  nq = {s, m_q[7:1]};
                ROTL: nq = {m_q[6:0], m_q[7]};
                ROTR: nq = {m_q[0], m_q[7:1]};
                ASR:  nq = {m_q[7], m_q[7:1]};
                default: begin nq = 8'h00; shift = 1'b0; end
            endcase
            if (m == LOAD || m == CLR) m_cnt = 0;
            m_wd = 1'b0;
            if (shift) begin
                m_cnt++;
                if (m_cnt == 8) begin
                    m_cnt = 0;
                    m_wd  = 1'b1;
                end
            end
            m_q = nq;
        end
        x.q  = m_q;
        x.wd = m_wd;
        x.so = (m == SHL || m == ROTL) ? m_q[7] : m_q[0];
        sb.push_back(x);
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        en    = 1'b0;
        mode  = HOLD;
        D     = 8'h00;
        sin   = 1'b0;
        #2;
        checks++;
        if (Q !== 8'h00 || word_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: Q=%h wd=%b, expected Q=00 wd=0", Q, word_done);
        end
        #10;
        reset = 1'b1;
        mode  = LOAD;
        D     = 8'hA5;
        en    = 1'b1;
        @(posedge Clk);
        #1;
        checks++;
        if (Q !== 8'hA5) begin
            errors++;
            $display("FAIL reset_release_load: Q=%h, expected a5", Q);
        end
        mode = HOLD;
        #(51 - $time);
        reset = 1'b0;
        #1;
        checks++;
        if (Q !== 8'h00 || Qb !== 8'hFF) begin
            errors++;
            $display("FAIL async_reset: Q=%h Qb=%h, expected Q=00 Qb=ff", Q, Qb);
        end
        @(negedge Clk);
        reset = 1'b1;
        m_q   = 8'h00;
        m_cnt = 0;
        m_wd  = 1'b0;
    endtask

    task automatic test_rotate();
        logic [2:0] ops [3] = '{LOAD, ROTL, ROTR};
        logic [7:0] want[3] = '{8'hA5, 8'h4B, 8'hA5};
        exp_t x;
        for (int i = 0; i < 3; i++) begin
            drive(ops[i], 8'hA5, 1'b0, 1'b1);
            x = sb.pop_front();
            checks++;
            if (Q !== x.q || sout !== x.so || word_done !== x.wd || Q !== want[i]) begin
                errors++;
                $display("FAIL rotate step %0d: Q=%h sout=%b wd=%b, expected Q=%h (%h) sout=%b wd=%b",
                         i, Q, sout, word_done, x.q, want[i], x.so, x.wd);
            end
            if (i == 1) begin
                checks++;
                if (sout !== 1'b0) begin
                    errors++;
                    $display("FAIL rotl_sout: sout=%b, expected 0", sout);
                end
            end
        end
    endtask

    task automatic test_shift();
        logic [2:0] ops [4] = '{LOAD, SHR, ASR, SHL};
        logic       sins[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [7:0] want[4] = '{8'h81, 8'hC0, 8'hE0, 8'hC0};
        exp_t x;
        for (int i = 0; i < 4; i++) begin
            drive(ops[i], 8'h81, sins[i], 1'b1);
            x = sb.pop_front();
            checks++;
            if (Q !== x.q || sout !== x.so || word_done !== x.wd || Q !== want[i]) begin
                errors++;
                $display("FAIL shift step %0d: Q=%h sout=%b wd=%b, expected Q=%h (%h) sout=%b wd=%b",
                         i, Q, sout, word_done, x.q, want[i], x.so, x.wd);
            end
        end
    endtask

    task automatic test_word_done();
        exp_t x;
        drive(LOAD, 8'h00, 1'b0, 1'b1);
        x = sb.pop_front();
        for (int i = 1; i <= 9; i++) begin
            drive(SHL, 8'h00, 1'b1, 1'b1);
            x = sb.pop_front();
            checks++;
            if (Q !== x.q || sout !== x.so || word_done !== x.wd || word_done !== (i == 8)) begin
                errors++;
                $display("FAIL word_done shift %0d: Q=%h wd=%b, expected Q=%h wd=%b",
                         i, Q, word_done, x.q, (i == 8));
            end
            if (i == 8) begin
                checks++;
                if (Q !== 8'hFF) begin
                    errors++;
                    $display("FAIL fill_ones: Q=%h, expected ff", Q);
                end
            end
        end
    endtask

    task automatic test_enable();
        exp_t       x;
        logic [7:0] prev;
        logic       e;
        drive(LOAD, 8'h00, 1'b0, 1'b1);
        x = sb.pop_front();
        for (int i = 1; i <= 12; i++) begin
            e    = !(i >= 3 && i <= 5);
            prev = Q;
            drive(SHL, 8'h00, i[0], e);
            x = sb.pop_front();
            checks++;
            if (Q !== x.q || sout !== x.so || word_done !== x.wd || word_done !== (i == 11)) begin
                errors++;
                $display("FAIL enable step %0d: Q=%h wd=%b, expected Q=%h wd=%b",
                         i, Q, word_done, x.q, (i == 11));
            end
            if (!e) begin
                checks++;
                if (Q !== prev) begin
                    errors++;
                    $display("FAIL enable_freeze step %0d: Q=%h, expected %h", i, Q, prev);
                end
            end
        end
    endtask

    task automatic test_clr();
        exp_t x;
        drive(LOAD, 8'hFF, 1'b0, 1'b1);
        x = sb.pop_front();
        for (int i = 0; i < 3; i++) begin
            drive(SHL, 8'h00, 1'b0, 1'b1);
            x = sb.pop_front();
        end
        drive(CLR, 8'h5A, 1'b1, 1'b1);
        x = sb.pop_front();
        checks++;
        if (Q !== 8'h00 || Q !== x.q || word_done !== 1'b0) begin
            errors++;
            $display("FAIL sync_clear: Q=%h wd=%b, expected Q=00 wd=0", Q, word_done);
        end
        for (int i = 1; i <= 8; i++) begin
            drive(ROTR, 8'h00, 1'b0, 1'b1);
            x = sb.pop_front();
            checks++;
            if (Q !== x.q || sout !== x.so || word_done !== x.wd || word_done !== (i == 8)) begin
                errors++;
                $display("FAIL clr_count step %0d: Q=%h wd=%b, expected Q=%h wd=%b",
                         i, Q, word_done, x.q, (i == 8));
            end
        end
    endtask

`ifdef USR_PARITY_EN
    task automatic test_parity();
        logic [7:0] vals[2] = '{8'h07, 8'h03};
        logic       want[2] = '{1'b1, 1'b0};
        exp_t x;
        for (int i = 0; i < 2; i++) begin
            drive(LOAD, vals[i], 1'b0, 1'b1);
            x = sb.pop_front();
            checks++;
            if (parity !== want[i] || Q !== x.q) begin
                errors++;
                $display("FAIL parity load %h: parity=%b Q=%h, expected parity=%b Q=%h",
                         vals[i], parity, Q, want[i], x.q);
            end
        end
    endtask
`endif

    initial begin
        m_q   = 8'h00;
        m_cnt = 0;
        m_wd  = 1'b0;
        test_reset();
        test_rotate();
        test_shift();
        test_word_done();
        test_enable();
        test_clr();
`ifdef USR_PARITY_EN
        test_parity();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
